// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared definitions for the instruction-ROM port arbiter.
//   owner_e      - which requester an access belongs to (F = fetch, D = debug)
//   s1_entry_t   - bookkeeping for the access currently waiting on the ROM
//   MISALIGN_MASK- byte-offset bits that must be zero for a word access
//   range_mask() - address bits that must be zero for a ROM of 2**aw words
package rom_arb_pkg;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } s1_entry_t;

  localparam logic [31:0] MISALIGN_MASK = 32'h0000_0003;

  // Bits [31:aw+2] of a byte address lie beyond the last ROM word.
  function automatic logic [31:0] range_mask(input int aw);
    return ~((32'd1 << (aw + 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// rom_arb_grant: picks at most one of the two read requests per cycle.
//   Build option ROM_ARB_RR_EN: when defined, contention is resolved
//   round-robin using a one-bit pointer; otherwise fetch has fixed priority
//   and no state is kept (the clock port only exists in the round-robin build).
// Ports:
//   clock    in  system clock (ROM_ARB_RR_EN only)
//   reset    in  asynchronous active-low reset; forces both grants low
//   f_req    in  fetch request
//   d_req    in  debug request
//   f_ready  out fetch granted this cycle (combinational)
//   d_ready  out debug granted this cycle (combinational)
// debug_ptr exposes the round-robin pointer for checkers (constant F when
// the fixed-priority build is selected).
module rom_arb_grant
  import rom_arb_pkg::*;
(
`ifdef ROM_ARB_RR_EN
  input  logic   clock,
`endif
  input  logic   reset,
  input  logic   f_req,
  input  logic   d_req,
  output logic   f_ready,
  output logic   d_ready,
  output owner_e debug_ptr
);

  logic f_win;

`ifdef ROM_ARB_RR_EN
  // ptr names the port that wins the next contended cycle.
  owner_e ptr;
  logic   contend;

  always_comb begin
    contend = f_req & d_req;
    f_win   = f_req & (~contend | (ptr == OWNER_F));
  end

  // Only a contended grant moves the pointer, so a lone requester never
  // steals the other port's turn.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= OWNER_F;
    end else if (contend) begin
      ptr <= f_win ? OWNER_D : OWNER_F;
    end
  end

  assign debug_ptr = ptr;
`else
  always_comb begin
    f_win = f_req;
  end

  assign debug_ptr = OWNER_F;
`endif

  always_comb begin
    f_ready = reset & f_win;
    d_ready = reset & d_req & ~f_win;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single instruction-ROM read port between the
// fetch stage (port F) and the debug/constant-load port (port D).
// Build option: ROM_ARB_RR_EN selects round-robin arbitration (default is
// fixed fetch priority); see rom_arb_grant.
//
// Handshake: a requester raises *_req with a stable *_addr and holds both
// until it sees *_ready high in the same cycle; the access is accepted at
// that posedge. Responses have no backpressure: *_rvalid pulses for exactly
// one cycle two edges after acceptance and the requester must take it then.
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   f_req/f_addr/f_ready  fetch request, byte address, grant
//   f_flush               drop the fetch access currently waiting on the ROM
//   f_rvalid/f_rdata/f_err fetch response pulse, word, error flag
//   d_*                   same for the debug port (no flush)
//   rom_addr              registered byte address to the ROM
//   rom_data              ROM read word, stable by the posedge after rom_addr
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ready,
  input  logic        f_flush,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [31:0] RANGE_MASK = range_mask(ADDR_WIDTH);

  s1_entry_t   s1;
  owner_e      grant_ptr;
  logic        accept;
  logic [31:0] acc_addr;
  logic        acc_err;
  logic        f_take;
  logic        d_take;

  rom_arb_grant u_grant (
`ifdef ROM_ARB_RR_EN
    .clock     (clock),
`endif
    .reset     (reset),
    .f_req     (f_req),
    .d_req     (d_req),
    .f_ready   (f_ready),
    .d_ready   (d_ready),
    .debug_ptr (grant_ptr)
  );

  // Acceptance side: select the granted address and classify it.
  always_comb begin
    accept   = f_ready | d_ready;
    acc_addr = d_ready ? d_addr : f_addr;
    acc_err  = (|(acc_addr & MISALIGN_MASK)) | (|(acc_addr & RANGE_MASK));
  end

  // S1: the access whose address is now presented to the ROM. An erroring
  // access keeps its slot (so per-port ordering and latency stay uniform)
  // but leaves rom_addr at the last good address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1       <= '0;
      rom_addr <= '0;
    end else begin
      s1.valid <= accept;
      s1.owner <= d_ready ? OWNER_D : OWNER_F;
      s1.err   <= acc_err;
      if (accept && !acc_err) begin
        rom_addr <= acc_addr;
      end
    end
  end

  // A flush only ever cancels the fetch entry; debug entries always retire.
  always_comb begin
    f_take = s1.valid && (s1.owner == OWNER_F) && !f_flush;
    d_take = s1.valid && (s1.owner == OWNER_D);
  end

  // Response stage: data registers only load on their own pulse, so each
  // port's rdata holds its last returned word between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      f_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      f_rvalid <= f_take;
      d_rvalid <= d_take;
      if (f_take) begin
        f_rdata <= s1.err ? 32'd0 : rom_data;
        f_err   <= s1.err;
      end
      if (d_take) begin
        d_rdata <= s1.err ? 32'd0 : rom_data;
        d_err   <= s1.err;
      end
    end
  end

  // The pointer is observable for checkers through the sub-module port only.
  logic unused_ptr;
  assign unused_ptr = grant_ptr;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed table, hand-written reset sequence and a
// randomized phase checked against a queue-based reference model.
module tb_rom_port_arbiter;

  logic        clock;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ready;
  logic        f_flush;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  int n_vec;
  int n_err;

  rom_port_arbiter #(.ADDR_WIDTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_ready  (f_ready),
    .f_flush  (f_flush),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .f_err    (f_err),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_ready  (d_ready),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- ROM model (samples address on negedge) ----------------
  logic [31:0] mem [256];
  always @(negedge clock) rom_data <= mem[rom_addr[9:2]];

  // ---------------- vector record ----------------
  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        ff;
    logic        dr;
    logic [31:0] da;
    logic        xfr;
    logic        xdr;
    logic        xfv;
    logic [31:0] xfd;
    logic        xfe;
    logic        xdv;
    logic [31:0] xdd;
    logic        xde;
    logic [31:0] xra;
  } vec_t;

  function automatic vec_t row(
    input logic fr, input logic [31:0] fa, input logic ff,
    input logic dr, input logic [31:0] da,
    input logic xfr, input logic xdr,
    input logic xfv, input logic [31:0] xfd, input logic xfe,
    input logic xdv, input logic [31:0] xdd, input logic xde,
    input logic [31:0] xra);
    vec_t v;
    v.fr = fr; v.fa = fa; v.ff = ff; v.dr = dr; v.da = da;
    v.xfr = xfr; v.xdr = xdr;
    v.xfv = xfv; v.xfd = xfd; v.xfe = xfe;
    v.xdv = xdv; v.xdd = xdd; v.xde = xde;
    v.xra = xra;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check grants, cross the edge, check outputs.
  task automatic apply(input vec_t v);
    f_req = v.fr; f_addr = v.fa; f_flush = v.ff;
    d_req = v.dr; d_addr = v.da;
    #1;
    check("f_ready", {31'd0, f_ready}, {31'd0, v.xfr});
    check("d_ready", {31'd0, d_ready}, {31'd0, v.xdr});
    @(posedge clock);
    #1;
    check("f_rvalid", {31'd0, f_rvalid}, {31'd0, v.xfv});
    check("f_rdata", f_rdata, v.xfd);
    if (v.xfv) check("f_err", {31'd0, f_err}, {31'd0, v.xfe});
    check("d_rvalid", {31'd0, d_rvalid}, {31'd0, v.xdv});
    check("d_rdata", d_rdata, v.xdd);
    if (v.xdv) check("d_err", {31'd0, d_err}, {31'd0, v.xde});
    check("rom_addr", rom_addr, v.xra);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        port;  // 0 = F, 1 = D
    logic [31:0] data;
    logic        err;
    int          due;
  } pend_t;

  pend_t       m_q[$];
  int          m_edge;
  logic        m_prefer_d;
  logic [31:0] m_rom;
  logic [31:0] m_fd;
  logic [31:0] m_dd;

  task automatic model_reset();
    m_q.delete();
    m_edge     = 0;
    m_prefer_d = 1'b0;
    m_rom      = 32'd0;
    m_fd       = 32'd0;
    m_dd       = 32'd0;
  endtask

  task automatic model_step(input logic fr, input logic [31:0] fa, input logic ff,
                            input logic dr, input logic [31:0] da, output vec_t v);
    logic        gf, gd, bad;
    logic [31:0] a;
    pend_t       p;
    v = row(fr, fa, ff, dr, da, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ROM_ARB_RR_EN
    if (fr && dr) begin
      gf = !m_prefer_d;
      m_prefer_d = gf;
    end else begin
      gf = fr;
    end
`else
    gf = fr;
`endif
    gd = dr && !gf;
    v.xfr = gf;
    v.xdr = gd;
    // edge: retire the access accepted one edge earlier
    m_edge++;
    if (m_q.size() > 0 && m_q[0].due == m_edge) begin
      p = m_q.pop_front();
      if (p.port) begin
        v.xdv = 1'b1; v.xde = p.err; m_dd = p.data;
      end else if (!ff) begin
        v.xfv = 1'b1; v.xfe = p.err; m_fd = p.data;
      end
    end
    if (gf || gd) begin
      a   = gd ? da : fa;
      bad = (a % 4 != 0) || (a >= 32'd1024);
      p.port = gd;
      p.err  = bad;
      p.data = bad ? 32'd0 : mem[a / 4];
      p.due  = m_edge + 1;
      m_q.push_back(p);
      if (!bad) m_rom = a;
    end
    v.xfd = m_fd;
    v.xdd = m_dd;
    v.xra = m_rom;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
    if (sel == 1) return 32'h400 + ($urandom_range(0, 4095) << 2);
    return $urandom_range(0, 255) << 2;
  endfunction

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    vec_t v;
    logic fr, dr, ff, f_hold, d_hold;
    logic [31:0] fa, da;

    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[3] = 32'h2008_0005;

    // reset state, grants suppressed while reset is low
    reset = 1'b0; f_req = 1'b1; f_addr = 32'h0; f_flush = 1'b0;
    d_req = 1'b1; d_addr = 32'h10;
    #2;
    check("reset f_ready", {31'd0, f_ready}, 32'd0);
    check("reset d_ready", {31'd0, d_ready}, 32'd0);
    check("reset rom_addr", rom_addr, 32'd0);
    check("reset f_rvalid", {31'd0, f_rvalid}, 32'd0);
    check("reset d_rdata", d_rdata, 32'd0);
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // single fetch, back-to-back fetch
    vecs.push_back(row(1, 32'hC, 0, 0, 0,   1, 0, 0, 32'h0, 0,         0, 32'h0, 0, 32'hC));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 1, 32'h20080005, 0,  0, 32'h0, 0, 32'hC));
    vecs.push_back(row(1, 32'h0, 0, 0, 0,   1, 0, 0, 32'h20080005, 0,  0, 32'h0, 0, 32'h0));
    vecs.push_back(row(1, 32'h4, 0, 0, 0,   1, 0, 1, 32'hA5000000, 0,  0, 32'h0, 0, 32'h4));
    vecs.push_back(row(1, 32'h8, 0, 0, 0,   1, 0, 1, 32'hA5000001, 0,  0, 32'h0, 0, 32'h8));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 1, 32'hA5000002, 0,  0, 32'h0, 0, 32'h8));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 0, 32'hA5000002, 0,  0, 32'h0, 0, 32'h8));
    // debug errors: misaligned, out of range; then a good debug read
    vecs.push_back(row(0, 0, 0, 1, 32'h2,   0, 1, 0, 32'hA5000002, 0,  0, 32'h0, 0, 32'h8));
    vecs.push_back(row(0, 0, 0, 1, 32'h400, 0, 1, 0, 32'hA5000002, 0,  1, 32'h0, 1, 32'h8));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 0, 32'hA5000002, 0,  1, 32'h0, 1, 32'h8));
    vecs.push_back(row(0, 0, 0, 1, 32'h10,  0, 1, 0, 32'hA5000002, 0,  0, 32'h0, 0, 32'h10));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 0, 32'hA5000002, 0,  1, 32'hA5000004, 0, 32'h10));
    // flush of F with D accepted in the flush cycle
    vecs.push_back(row(1, 32'h4, 0, 0, 0,   1, 0, 0, 32'hA5000002, 0,  0, 32'hA5000004, 0, 32'h4));
    vecs.push_back(row(0, 0, 1, 1, 32'hC,   0, 1, 0, 32'hA5000002, 0,  0, 32'hA5000004, 0, 32'hC));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 0, 32'hA5000002, 0,  1, 32'h20080005, 0, 32'hC));
    // flush while a new fetch is accepted in the same cycle
    vecs.push_back(row(1, 32'h0, 0, 0, 0,   1, 0, 0, 32'hA5000002, 0,  0, 32'h20080005, 0, 32'h0));
    vecs.push_back(row(1, 32'h4, 1, 0, 0,   1, 0, 0, 32'hA5000002, 0,  0, 32'h20080005, 0, 32'h4));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 1, 32'hA5000001, 0,  0, 32'h20080005, 0, 32'h4));
    vecs.push_back(row(0, 0, 0, 0, 0,       0, 0, 0, 32'hA5000001, 0,  0, 32'h20080005, 0, 32'h4));
    // contention: both held 4 cycles, F at 0x0, D at 0x10
`ifdef ROM_ARB_RR_EN
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 1, 0, 0, 32'hA5000001, 0, 0, 32'h20080005, 0, 32'h0));
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 0, 1, 1, 32'hA5000000, 0, 0, 32'h20080005, 0, 32'h10));
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 1, 0, 0, 32'hA5000000, 0, 1, 32'hA5000004, 0, 32'h0));
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 0, 1, 1, 32'hA5000000, 0, 0, 32'hA5000004, 0, 32'h10));
    vecs.push_back(row(0, 0, 0, 0, 0,          0, 0, 0, 32'hA5000000, 0, 1, 32'hA5000004, 0, 32'h10));
`else
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 1, 0, 0, 32'hA5000001, 0, 0, 32'h20080005, 0, 32'h0));
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 1, 0, 1, 32'hA5000000, 0, 0, 32'h20080005, 0, 32'h0));
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 1, 0, 1, 32'hA5000000, 0, 0, 32'h20080005, 0, 32'h0));
    vecs.push_back(row(1, 32'h0, 0, 1, 32'h10, 1, 0, 1, 32'hA5000000, 0, 0, 32'h20080005, 0, 32'h0));
    vecs.push_back(row(0, 0, 0, 0, 0,          0, 0, 1, 32'hA5000000, 0, 0, 32'h20080005, 0, 32'h0));
`endif
    foreach (vecs[i]) apply(vecs[i]);

    // reset mid-stream: F accepted, reset asserted during the next cycle
    f_req = 1'b1; f_addr = 32'h8; d_req = 1'b0; f_flush = 1'b0;
    #1;
    check("mid f_ready", {31'd0, f_ready}, 32'd1);
    @(posedge clock);
    #1;
    f_req = 1'b0;
    check("mid rom_addr accepted", rom_addr, 32'h8);
    #3;
    reset = 1'b0;
    #1;
    check("mid rom_addr cleared", rom_addr, 32'd0);
    check("mid f_rdata cleared", f_rdata, 32'd0);
    check("mid d_rdata cleared", d_rdata, 32'd0);
    f_req = 1'b1;
    #1;
    check("mid f_ready in reset", {31'd0, f_ready}, 32'd0);
    @(posedge clock);
    #1;
    f_req = 1'b0;
    check("mid f_rvalid in reset", {31'd0, f_rvalid}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      check("post f_rvalid", {31'd0, f_rvalid}, 32'd0);
      check("post f_rdata", f_rdata, 32'd0);
      check("post rom_addr", rom_addr, 32'd0);
    end

    // randomized phase against the reference model
    model_reset();
    f_hold = 1'b0; d_hold = 1'b0;
    fr = 1'b0; dr = 1'b0; fa = 32'd0; da = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (!f_hold) begin
        fr = ($urandom_range(0, 1) == 1);
        fa = rand_addr();
      end
      if (!d_hold) begin
        dr = ($urandom_range(0, 2) == 0);
        da = rand_addr();
      end
      ff = ($urandom_range(0, 3) == 0);
      model_step(fr, fa, ff, dr, da, v);
      apply(v);
      f_hold = fr && !v.xfr;
      d_hold = dr && !v.xdr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single instruction ROM read port between two requesters: the instruction-fetch stage (port F) and the debug/constant-load port (port D). Accepts at most one read per cycle, drives the ROM address, tags the access with its owner, and routes the returned word back with a one-cycle `valid` pulse. Sits between the fetch/debug logic and `inst_rom`.

## Interface
- `ADDR_WIDTH`, 8: ROM word-address bits; must match the ROM instance.
- `clock` in 1: system clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `f_req` in 1: fetch read request; hold until accepted.
- `f_addr` in 32: fetch byte address.
- `f_ready` out 1: fetch request accepted this cycle (combinational grant).
- `f_flush` in 1: discard any fetch access already in flight.
- `f_rvalid` out 1: one-cycle pulse, `f_rdata`/`f_err` valid.
- `f_rdata` out 32: returned word.
- `f_err` out 1: access was misaligned or out of range.
- `d_req`, `d_addr`, `d_ready`, `d_rvalid`, `d_rdata`, `d_err`: same meanings for the debug port. No flush.
- `rom_addr` out 32: registered byte address to ROM `addr_in`.
- `rom_data` in 32: ROM `data_out`.

## Operation
- Arbitration each cycle among asserted `*_req`. A grant asserts exactly one `*_ready`. The request is accepted at that posedge.
- Address check at acceptance:
  - `addr[1:0] != 0` marks the access as an error.
  - `addr[31:ADDR_WIDTH+2] != 0` marks the access as an error.
  - An error access still occupies its slot but does not update `rom_addr`.
- Pipeline stage S1, registered at acceptance: `s1_valid`, `s1_owner` (F/D), `s1_err`, and `rom_addr` (non-error accesses only).
- The ROM samples `rom_addr` on the following negedge. `rom_data` is stable by the next posedge.
- Response stage, registered at the next posedge:
  - Owner's `*_rvalid`=1.
  - `*_rdata` = `rom_data`, or 0 if error.
  - `*_err` = `s1_err`.
  - The other port's `rvalid`=0.
- Flush: while `f_flush`=1, an S1 entry owned by F is dropped, and `f_rvalid` stays 0 at the next edge. A fetch request in the same cycle is still arbitrated and accepted normally. D entries are unaffected.
- No response backpressure. Requesters must consume `rvalid` when it pulses. `*_rdata` holds its last value when `rvalid`=0.
- Reset (asynchronous, any time) clears the following:
  - `s1_valid`=0.
  - `rom_addr`=0.
  - All `*_rvalid`=0, `*_rdata`=0, `*_err`=0.
  - Arbitration pointer = F.
  - In-flight accesses are lost.

## Timing
- Throughput: one access per cycle, back-to-back, with no bubbles.
- Latency: accepted at edge E0 → `*_rvalid` high in the cycle after E0+1 (2 edges).
- `*_ready` is combinational from `*_req`, the arbitration pointer, and `reset`. It is 0 while `reset`=0.
- The output ordering for a given port equals its acceptance order.

## Configuration
- `ROM_ARB_RR_EN` defined:
  - Round-robin. On contention the port not granted last wins.
  - The pointer updates only on a contended grant.
- `ROM_ARB_RR_EN` undefined:
  - Fixed priority. F always wins and D is served only when `f_req`=0.
  - The pointer register is omitted.

## Structure
- Shared package `rom_arb_pkg`:
  - owner encoding (`OWNER_F`=0, `OWNER_D`=1);
  - S1 entry struct (valid, owner, err);
  - misalignment mask constant.
- One sub-module `rom_arb_grant`: combinational grant logic plus the pointer register (present only with `ROM_ARB_RR_EN`).
- Datapath/pipeline registers stay in the top.

## Test plan
- Reset mid-stream:
  - Stimulus: pull `reset` low one cycle after an F access is accepted.
  - Response: no `f_rvalid` afterward; `rom_addr`=0; `f_rdata`=0 until the next access.
- Single fetch:
  - Stimulus: ROM word 3 = 0x20080005; `f_req`=1, `f_addr`=0x0000000C for one accepted cycle.
  - Response: `rom_addr`=0x0C after E0; `f_rvalid`=1 with `f_rdata`=0x20080005, `f_err`=0 after E0+1.
- Back-to-back fetch:
  - Stimulus: `f_addr` = 0x0, 0x4, 0x8 on consecutive cycles.
  - Response: three consecutive `f_rvalid` pulses carrying ROM words 0, 1, 2 in order.
- Contention:
  - Stimulus: both requests held for 4 cycles, F at 0x0, D at 0x10.
  - Response with `ROM_ARB_RR_EN`: grants F, D, F, D.
  - Response without it: `d_ready` stays 0 for all 4 cycles.
- Errors:
  - Stimulus: `d_addr`=0x00000002; then `d_addr`=0x00000400 with `ADDR_WIDTH`=8.
  - Response: each gives `d_rvalid`=1, `d_err`=1, `d_rdata`=0; `rom_addr` is unchanged.
- Flush:
  - Stimulus: F accepted at E0; `f_flush`=1 in the following cycle; D is accepted in that same cycle.
  - Response: no `f_rvalid` for the flushed access; D's `d_rvalid` arrives on schedule.
